// File: rtl/dca_lsu_axi_read_issuer.sv
// Pops LSU transaction descriptors, issues AXI AR bursts, and emits one
// in-order completion pulse per descriptor as R-channel bursts retire.
module dca_lsu_axi_read_issuer #(
  parameter int BW_ADDR         = 32,
  parameter int BW_BITADDR      = BW_ADDR + 3,
  parameter int BW_ALEN         = 8,
  parameter int BW_DATA         = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int BW_TXN_INFO     = 2 + BW_ALEN + BW_BITADDR
) (
  input  logic                                clk,
  input  logic                                rstnn,
  input  logic                                enable,
  input  logic                                clear,
  input  logic                                txn_ready,
  input  logic [BW_TXN_INFO-1:0]              txn_info,
  output logic                                txn_request,
  output logic [BW_ADDR-1:0]                  araddr,
  output logic [BW_ALEN-1:0]                  arlen,
  output logic [2:0]                          arsize,
  output logic [1:0]                          arburst,
  output logic                                arvalid,
  input  logic                                arready,
  input  logic                                r_beat_last,
  output logic                                done_valid,
  output logic                                done_last,
  output logic                                busy,
  output logic [$clog2(MAX_OUTSTANDING):0]    outstanding
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int OW = PW + 1;
  localparam logic [BW_ADDR-1:0] BEAT_MASK = ~BW_ADDR'(BW_DATA/8 - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DRAIN} state_e;

  typedef struct packed {
    logic                  last;
    logic                  dummy;
    logic [BW_ALEN-1:0]    alen;
    logic [BW_BITADDR-1:0] bitaddr;
  } txn_t;

  state_e               state_q, state_d;
  logic [OW-1:0]        out_q, out_d;
  logic [BW_ADDR-1:0]   araddr_q, araddr_d;
  logic [BW_ALEN-1:0]   arlen_q, arlen_d;
  logic                 pend_q, pend_d;
  logic                 done_v_q, done_v_d;
  logic                 done_l_q, done_l_d;
  logic [PW-1:0]        wptr_q, rptr_q;
  logic                 tags_q [MAX_OUTSTANDING];

  txn_t                 txn;
  logic [BW_ADDR-1:0]   byte_addr;
  logic                 inc, dec, slot_ok, pop;
  logic [OW:0]          occ_next;

  assign txn       = txn_info;
  assign byte_addr = txn.bitaddr[BW_ADDR+2:3];

  // Slot check counts this cycle's handshake and retirement so a pop in ADDR
  // can never push the tag FIFO past its depth.
  assign inc      = (state_q == S_ADDR) & arready;
  assign dec      = r_beat_last & (out_q != '0);
  assign occ_next = {1'b0, out_q} + (OW+1)'(inc) - (OW+1)'(dec);
  assign slot_ok  = occ_next < (OW+1)'(MAX_OUTSTANDING);
  assign pop      = enable & txn_ready & slot_ok & ~clear &
                    ((state_q == S_IDLE) | ((state_q == S_ADDR) & arready));

  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    pend_d   = pend_q;
    done_v_d = 1'b0;
    done_l_d = 1'b0;
    out_d    = out_q + OW'(inc) - OW'(dec);
    case (state_q)
      S_ADDR:  if (arready) state_d = S_IDLE;
      S_DRAIN: if ((out_q == '0) && !dec) begin
        done_v_d = 1'b1;
        done_l_d = pend_q;
        state_d  = S_IDLE;
      end
      default: ;
    endcase
    if (pop) begin
      pend_d = txn.last;
      if (txn.dummy) begin
        state_d = S_DRAIN;
      end else begin
        state_d  = S_ADDR;
        araddr_d = byte_addr & BEAT_MASK;
        arlen_d  = txn.alen;
      end
    end
    if (dec) begin
      done_v_d = 1'b1;
      done_l_d = tags_q[rptr_q];
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q  <= S_IDLE;
      out_q    <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
      pend_q   <= 1'b0;
      done_v_q <= 1'b0;
      done_l_q <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
    end else if (clear) begin
      state_q  <= S_IDLE;
      out_q    <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
      pend_q   <= 1'b0;
      done_v_q <= 1'b0;
      done_l_q <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      pend_q   <= pend_d;
      done_v_q <= done_v_d;
      done_l_q <= done_l_d;
      if (inc) wptr_q <= wptr_q + 1'b1;
      if (dec) rptr_q <= rptr_q + 1'b1;
    end
  end

  // Tag storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (inc) tags_q[wptr_q] <= pend_q;
  end

  assign txn_request = pop;
  assign araddr      = araddr_q;
  assign arlen       = arlen_q;
  assign arsize      = 3'($clog2(BW_DATA/8));
  assign arburst     = 2'b01;
  assign arvalid     = (state_q == S_ADDR);
  assign done_valid  = done_v_q;
  assign done_last   = done_l_q;
  assign busy        = (state_q != S_IDLE) | (out_q != '0);
  assign outstanding = out_q;
endmodule

// File: tb/tb_dca_lsu_axi_read_issuer.sv
// Randomized + directed bench: reference queues of expected AR bursts and
// completions, checked by an independent monitor process.
module tb_dca_lsu_axi_read_issuer;
  localparam int BW_ADDR = 32, BW_BITADDR = 35, BW_ALEN = 8, BW_DATA = 32, MAXO = 4;
  localparam int BW_TXN = 2 + BW_ALEN + BW_BITADDR;

  logic clk = 1'b0, rstnn = 1'b0, enable = 1'b0, clear = 1'b0;
  logic txn_ready = 1'b0, arready = 1'b0, r_beat_last = 1'b0;
  logic [BW_TXN-1:0] txn_info = '0;
  logic txn_request, arvalid, done_valid, done_last, busy;
  logic [BW_ADDR-1:0] araddr;
  logic [BW_ALEN-1:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic [2:0] outstanding;

  dca_lsu_axi_read_issuer #(.BW_ADDR(BW_ADDR), .BW_BITADDR(BW_BITADDR), .BW_ALEN(BW_ALEN),
    .BW_DATA(BW_DATA), .MAX_OUTSTANDING(MAXO), .BW_TXN_INFO(BW_TXN)) dut (
    .clk(clk), .rstnn(rstnn), .enable(enable), .clear(clear), .txn_ready(txn_ready),
    .txn_info(txn_info), .txn_request(txn_request), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .r_beat_last(r_beat_last), .done_valid(done_valid), .done_last(done_last),
    .busy(busy), .outstanding(outstanding));

  always #5 clk = ~clk;

  typedef struct { logic last; logic dummy; logic [7:0] alen; logic [34:0] bitaddr; } desc_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;

  desc_t up_q[$];
  ar_t   exp_ar[$];
  logic  exp_done[$];
  int    n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
  endtask

  // Byte address = bit address / 8, kept to 32 bits, rounded down to a beat.
  function automatic logic [31:0] model_addr(input logic [34:0] b);
    logic [63:0] w;
    w = (64'(b) / 64'd8) % 64'h1_0000_0000;
    return 32'(w - (w % 64'(BW_DATA/8)));
  endfunction

  task automatic push_desc(input logic l, input logic d, input logic [7:0] a, input logic [34:0] b);
    desc_t x;
    ar_t e;
    x.last = l; x.dummy = d; x.alen = a; x.bitaddr = b;
    up_q.push_back(x);
    exp_done.push_back(l);
    if (!d) begin
      e.addr = model_addr(b); e.len = a;
      exp_ar.push_back(e);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    txn_ready = (up_q.size() != 0);
    if (up_q.size() != 0) txn_info = {up_q[0].last, up_q[0].dummy, up_q[0].alen, up_q[0].bitaddr};
    else txn_info = '0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((up_q.size() != 0 || exp_done.size() != 0 || busy) && i < 3000) begin
      tick(); enable = 1'b1; arready = 1'($urandom % 2); r_beat_last = 1'($urandom % 2); i++;
    end
    tick(); r_beat_last = 1'b0; arready = 1'b0; #2;
    chk("drain_done_queue", 64'(exp_done.size()), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);
  endtask

  // Monitor: compares DUT outputs against the expectation queues each cycle.
  initial begin
    int mod_out;
    logic due, stall, el;
    logic [31:0] paddr;
    logic [7:0] plen;
    ar_t e;
    desc_t dt;
    mod_out = 0; due = 1'b0; stall = 1'b0; paddr = '0; plen = '0;
    forever begin
      @(negedge clk); #1;
      if (!rstnn) begin
        mod_out = 0; due = 1'b0; stall = 1'b0;
        up_q.delete(); exp_ar.delete(); exp_done.delete();
      end else begin
        chk("outstanding", 64'(outstanding), 64'(mod_out));
        if (due) chk("done_latency", 64'(done_valid), 64'd1);
        if (done_valid) begin
          if (exp_done.size() == 0) chk("spurious_done", 64'(done_valid), 64'd0);
          else begin el = exp_done.pop_front(); chk("done_last", 64'(done_last), 64'(el)); end
        end
        if (stall) begin
          chk("stall_arvalid", 64'(arvalid), 64'd1);
          chk("stall_araddr", 64'(araddr), 64'(paddr));
          chk("stall_arlen", 64'(arlen), 64'(plen));
        end
        if (txn_request) begin
          if (up_q.size() == 0) chk("pop_empty", 64'(txn_request), 64'd0);
          else dt = up_q.pop_front();
        end
        if (arvalid && arready) begin
          if (exp_ar.size() == 0) chk("ar_unexpected", 64'(arvalid), 64'd0);
          else begin
            e = exp_ar.pop_front();
            chk("araddr", 64'(araddr), 64'(e.addr));
            chk("arlen", 64'(arlen), 64'(e.len));
          end
        end
        due = r_beat_last && (mod_out > 0);
        mod_out += int'(arvalid && arready) - int'(due);
        stall = arvalid && !arready; paddr = araddr; plen = arlen;
        if (clear) begin mod_out = 0; due = 1'b0; stall = 1'b0; end
      end
    end
  end

  initial begin
    #1;
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_done_valid", 64'(done_valid), 64'd0);
    chk("rst_done_last", 64'(done_last), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_araddr", 64'(araddr), 64'd0);
    chk("rst_arlen", 64'(arlen), 64'd0);
    chk("arsize", 64'(arsize), 64'd2);
    chk("arburst", 64'(arburst), 64'd1);
    #20; @(negedge clk); rstnn = 1'b1;

    // Single burst, then a misaligned one
    push_desc(1'b1, 1'b0, 8'd3, 35'h800);
    tick(); enable = 1'b1; arready = 1'b1; #2;
    chk("txn_request_first", 64'(txn_request), 64'd1);
    tick(); #2;
    chk("single_araddr", 64'(araddr), 64'h100);
    chk("single_arvalid", 64'(arvalid), 64'd1);
    chk("txn_request_once", 64'(txn_request), 64'd0);
    tick(); tick(); r_beat_last = 1'b1;
    tick(); r_beat_last = 1'b0; #2;
    chk("single_done_valid", 64'(done_valid), 64'd1);
    chk("single_done_last", 64'(done_last), 64'd1);
    tick(); #2;
    chk("single_out_zero", 64'(outstanding), 64'd0);
    chk("single_busy", 64'(busy), 64'd0);
    push_desc(1'b0, 1'b0, 8'h0f, 35'h8A7);
    drain();

    // Six descriptors against four slots
    for (int k = 0; k < 6; k++) push_desc(1'(k == 5), 1'b0, 8'(k), 35'(k * 64 + 5));
    enable = 1'b1; arready = 1'b1; r_beat_last = 1'b0;
    repeat (14) tick();
    #2;
    chk("full_outstanding", 64'(outstanding), 64'd4);
    chk("full_no_request", 64'(txn_request), 64'd0);
    chk("full_q_left", 64'(up_q.size()), 64'd2);
    tick(); r_beat_last = 1'b1;
    tick(); r_beat_last = 1'b0;
    repeat (4) tick();
    #2;
    chk("refill_q_left", 64'(up_q.size()), 64'd1);
    chk("refill_outstanding", 64'(outstanding), 64'd4);

    // Hold AR stalled at outstanding=2 with a descriptor waiting
    tick(); arready = 1'b0; r_beat_last = 1'b1;
    tick(); r_beat_last = 1'b1;
    tick(); r_beat_last = 1'b0;
    push_desc(1'b1, 1'b0, 8'd7, 35'h1_0000);
    repeat (5) begin
      tick(); enable = 1'($urandom % 2); #2;
      chk("bp_arvalid", 64'(arvalid), 64'd1);
      chk("bp_no_pop", 64'(txn_request), 64'd0);
    end
    tick(); enable = 1'b1; arready = 1'b1; r_beat_last = 1'b1; #2;
    chk("coincide_pre", 64'(outstanding), 64'd2);
    tick(); r_beat_last = 1'b0; arready = 1'b0; #2;
    chk("coincide_out", 64'(outstanding), 64'd2);
    drain();

    // Dummy completion waits for the preceding burst
    push_desc(1'b0, 1'b0, 8'd1, 35'h1_2340);
    push_desc(1'b1, 1'b1, 8'd0, 35'h0);
    enable = 1'b1; arready = 1'b1;
    repeat (6) tick();
    #2;
    chk("dummy_wait_out", 64'(outstanding), 64'd1);
    chk("dummy_no_pulse", 64'(done_valid), 64'd0);
    tick(); r_beat_last = 1'b1;
    tick(); r_beat_last = 1'b0; #2;
    chk("dummy_a_pulse", 64'(done_valid), 64'd1);
    chk("dummy_a_last", 64'(done_last), 64'd0);
    tick(); #2;
    chk("dummy_d_pulse", 64'(done_valid), 64'd1);
    chk("dummy_d_last", 64'(done_last), 64'd1);
    tick(); #2;
    chk("dummy_idle", 64'(busy), 64'd0);

    // Stray R last while idle, then a clear while idle
    tick(); r_beat_last = 1'b1;
    tick(); r_beat_last = 1'b0; #2;
    chk("stray_r_done", 64'(done_valid), 64'd0);
    chk("stray_r_out", 64'(outstanding), 64'd0);
    tick(); clear = 1'b1;
    tick(); clear = 1'b0; #2;
    chk("clear_busy", 64'(busy), 64'd0);

    // Random traffic
    repeat (600) begin
      tick();
      if (up_q.size() < 3 && ($urandom % 2) == 1)
        push_desc(1'($urandom % 2), 1'(($urandom % 5) == 0), 8'($urandom),
                  {3'($urandom), 32'($urandom)});
      enable = 1'(($urandom % 4) != 0);
      arready = 1'(($urandom % 3) != 0);
      r_beat_last = 1'(($urandom % 3) == 0);
    end
    drain();

    // Asynchronous reset in the middle of an AR stall
    push_desc(1'b0, 1'b0, 8'd5, 35'h4000);
    enable = 1'b1; arready = 1'b0;
    repeat (3) tick();
    #2;
    chk("rst_pre_arvalid", 64'(arvalid), 64'd1);
    #1 rstnn = 1'b0;
    #1;
    chk("rst_mid_arvalid", 64'(arvalid), 64'd0);
    chk("rst_mid_out", 64'(outstanding), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    tick();
    tick(); rstnn = 1'b1;
    repeat (3) tick();
    #2;
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("final_ar_queue", 64'(exp_ar.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
